// File: rtl/pc_fetch.sv
// pc_fetch: architectural PC register and instruction-fetch sequencer.
// Issues one word fetch per instruction over imem req/ack, presents the word
// to decode over inst_valid/inst_ready, and computes the next PC when decode
// accepts the instruction.
//
// Handshakes:
//   imem: imem_req is held high with imem_addr stable until a rising edge that
//         sees imem_ack=1; that edge completes the fetch. imem_ack outside REQ
//         is ignored.
//   decode: inst_valid is held high with inst stable until a rising edge that
//         sees inst_ready=1; that edge is the acceptance edge. inst_ready
//         outside HOLD is ignored.
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic [1:0]  npc_sel,
   input  logic        br_taken,
   input  logic [15:0] imm16,
   input  logic [25:0] target26,
   input  logic [31:0] rs_val,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   output logic        addr_err,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2,
      ERR  = 2'd3
   } state_e;

   localparam logic [1:0] SEL_SEQ    = 2'b00;
   localparam logic [1:0] SEL_BRANCH = 2'b01;
   localparam logic [1:0] SEL_JUMP   = 2'b10;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;

   logic [31:0] pc4_w;
   logic [31:0] br_off_w;
   logic [31:0] npc_w;

   assign pc4_w    = pc_q + 32'd4;
   assign br_off_w = {{14{imm16[15]}}, imm16, 2'b00};

   // Next-PC selection; only consumed at the acceptance edge.
   always_comb begin
      npc_w = pc4_w;
      case (npc_sel)
         SEL_SEQ:    npc_w = pc4_w;
         SEL_BRANCH: npc_w = br_taken ? (pc4_w + br_off_w) : pc4_w;
         SEL_JUMP:   npc_w = {pc4_w[31:28], target26, 2'b00};
         default:    npc_w = rs_val;
      endcase
   end

   // Fetch sequencer next-state and register next values.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      valid_d = valid_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            state_d = REQ;
         end
         REQ: begin
            if (imem_ack) begin
               inst_d  = imem_rdata;
               valid_d = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (inst_ready) begin
               valid_d = 1'b0;
               pc_d    = npc_w;
               if (npc_w[1:0] != 2'b00) begin
                  err_d   = 1'b1;
                  state_d = ERR;
               end else begin
                  state_d = REQ;
               end
            end
         end
         ERR: begin
            // Terminal until reset; pc keeps the misaligned value.
            state_d = ERR;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any outstanding fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         inst_q  <= 32'd0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign imem_req   = (state_q == REQ);
   assign imem_addr  = pc_q;
   assign inst       = inst_q;
   assign inst_valid = valid_q;
   assign pc         = pc_q;
   assign pc4        = pc4_w;
   assign addr_err   = err_q;
   assign state_dbg  = state_q;

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter register and instruction-fetch sequencer for the 31-instruction MIPS CPU. Holds the architectural PC and issues one word fetch per instruction to instruction memory over a req/ack handshake. Presents each fetched word to decode over a valid/ready handshake. On acceptance it computes the next PC internally (sequential, branch, jump, jr), so it is the consumer and owner of the PC+4 value.

## Interface
Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch byte address; equals pc.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- inst  out  32  registered instruction to decode.
- inst_valid  out  1  inst holds an unconsumed instruction.
- inst_ready  in  1  decode accepts inst this cycle.
- npc_sel  in  2  next-PC source: 00 seq, 01 branch, 10 j/jal, 11 jr; sampled at acceptance.
- br_taken  in  1  branch condition; used only when npc_sel=01.
- imm16  in  16  branch offset, in words.
- target26  in  26  jump index field.
- rs_val  in  32  jr target register value.
- pc  out  32  PC of the instruction being fetched or held.
- pc4  out  32  pc+4, combinational, for the jal link value.
- addr_err  out  1  sticky: a misaligned next PC was produced.

## Operation
- States: IDLE, REQ, HOLD, ERR.
- IDLE: entered on reset; the next state is always REQ.
- REQ: imem_req=1 and imem_addr=pc, held stable until ack. On an edge with imem_ack=1: inst<=imem_rdata, inst_valid<=1, go to HOLD.
- HOLD: imem_req=0; inst and inst_valid are held while inst_ready=0. On an edge with inst_ready=1: inst_valid<=0 and pc<=npc. If npc[1:0]!=0, set addr_err<=1 and go to ERR; otherwise go to REQ.
- ERR: terminal until reset. imem_req=0, inst_valid=0, pc holds the misaligned value.
- npc, all arithmetic modulo 2^32:
  - seq: pc+4.
  - branch: br_taken ? pc+4+({{14{imm16[15]}},imm16,2'b00}) : pc+4.
  - jump: {pc4[31:28],target26,2'b00}.
  - jr: rs_val.
- imem_ack outside REQ is ignored. inst_ready outside HOLD is ignored.
- npc_sel, br_taken, imm16, target26 and rs_val are don't-care except at the acceptance edge.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, inst=0, inst_valid=0, addr_err=0. pc4 = RESET_PC+4.
- Cycle 1 after rst_n deasserts: REQ, with imem_req=1.
- Ack latency: ack is allowed in the same cycle req first rises. inst_valid is high in the cycle after the ack edge.
- Best-case throughput: one instruction per 2 cycles (REQ, HOLD).
- pc updates at the acceptance edge. The new imem_addr is visible in the following REQ cycle.
- Wrap-around: pc=32'hFFFF_FFFC with seq gives pc=0 with no error.
- Reset asserted mid-transaction, in any state: all outputs take reset values immediately. The outstanding fetch is abandoned and a late ack is ignored.

## Test plan
- Reset/sequential: release reset, ack every REQ in the same cycle, hold inst_ready=1 → fetch addresses 0x00400000, 0x00400004, 0x00400008. Each inst equals the returned rdata, and inst_valid pulses one cycle per fetch.
- Handshake stalls: delay ack 3 cycles, then hold inst_ready low 4 cycles → imem_addr stays stable throughout REQ, inst and inst_valid stay stable throughout HOLD, and exactly one fetch occurs per instruction.
- Branch: pc=0x00400010, npc_sel=01, br_taken=1, imm16=16'hFFFC → next pc=0x00400004. Same stimulus with br_taken=0 → next pc=0x00400014.
- Jump/jr: pc=0x00400000, npc_sel=10, target26=26'h0100008 → next pc=0x00400020. npc_sel=11, rs_val=0x00400100 → next pc=0x00400100.
- Misaligned jr: npc_sel=11, rs_val=0x00400102 → addr_err=1, pc=0x00400102, imem_req stays 0. rst_n low then high → addr_err=0 and fetch restarts at 0x00400000.
- Wrap and abort: RESET_PC=32'hFFFF_FFFC, seq accept → pc=0. Separately, assert rst_n low during REQ and then drive a late ack → inst_valid stays 0.
